// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: free-run at the divided rate, debounced single-step, CPU halt.
// Everything runs in the clk domain. The slow divider output, the button and the switch are synchronized first.
module cpu_step_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_W      = 20,
  parameter int unsigned STEP_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slow_tick_in,
  input  logic              btn_step,
  input  logic              sw_run,
  input  logic              halt_req,
  output logic              cpu_en,
  output logic [STEP_W-1:0] step_count,
  output logic [1:0]        state,
  output logic              btn_clean
);

  typedef enum logic [1:0] {
    STOP      = 2'd0,
    RUN       = 2'd1,
    STEP_WAIT = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t          state_q;
  logic            tick_s1, tick_s2, tick_prev;
  logic            btn_s1, btn_s2;
  logic            run_s1, run_s2;
  logic            btn_clean_d;
  logic [DB_W-1:0] db_cnt;
  logic            tick_pulse;
  logic            step_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_s1   <= 1'b0;
      tick_s2   <= 1'b0;
      tick_prev <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      run_s1    <= 1'b0;
      run_s2    <= 1'b0;
    end else begin
      tick_s1   <= slow_tick_in;
      tick_s2   <= tick_s1;
      tick_prev <= tick_s2;
      btn_s1    <= btn_step;
      btn_s2    <= btn_s1;
      run_s1    <= sw_run;
      run_s2    <= run_s1;
    end
  end

  assign tick_pulse = tick_s2 & ~tick_prev;

  // A change is accepted only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      btn_clean_d <= 1'b0;
    end else begin
      btn_clean_d <= btn_clean;
      if (btn_s2 != btn_clean) begin
        if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          btn_clean <= btn_s2;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign step_req = btn_clean & ~btn_clean_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
      cpu_en  <= 1'b0;
    end else begin
      cpu_en <= 1'b0;
      case (state_q)
        STOP: begin
          if (run_s2)        state_q <= RUN;
          else if (step_req) state_q <= STEP_WAIT;
        end
        RUN: begin
          if (!run_s2)       state_q <= STOP;
          else if (halt_req) state_q <= HALT;
          else               cpu_en  <= tick_pulse;
        end
        STEP_WAIT: begin
          if (run_s2) begin
            state_q <= RUN;
          end else if (tick_pulse) begin
            cpu_en  <= 1'b1;
            state_q <= STOP;
          end
        end
        HALT: begin
          if (!run_s2) state_q <= STOP;
        end
        default: state_q <= STOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         step_count <= '0;
    else if (cpu_en) step_count <= step_count + 1'b1;
  end

  assign state = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed-plus-random bench for cpu_step_ctrl; expected pulses and counts come from a simple event model.
module tb_cpu_step_ctrl;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_tick_in = 1'b0;
  logic          btn_step = 1'b0;
  logic          sw_run = 1'b0;
  logic          halt_req = 1'b0;
  logic          cpu_en;
  logic [SW-1:0] step_count;
  logic [1:0]    state;
  logic          btn_clean;

  int checks = 0;
  int errors = 0;
  int pulses_seen = 0;
  int rises_seen = 0;
  int exp_pulses = 0;
  int exp_rises = 0;
  int exp_count = 0;

  cpu_step_ctrl #(.DB_CYCLES(4), .DB_W(3), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .slow_tick_in(slow_tick_in), .btn_step(btn_step),
    .sw_run(sw_run), .halt_req(halt_req), .cpu_en(cpu_en), .step_count(step_count),
    .state(state), .btn_clean(btn_clean)
  );

  always #5 clk = ~clk;

  logic prev_en = 1'b0;
  logic prev_clean = 1'b0;
  always @(negedge clk) begin
    if (cpu_en === 1'b1) begin
      pulses_seen++;
      checks++;
      assert (prev_en !== 1'b1) else begin
        errors++;
        $error("FAIL back_to_back observed cpu_en=1 twice expected single-cycle pulse");
      end
    end
    if (btn_clean === 1'b1 && prev_clean === 1'b0) rises_seen++;
    prev_en    = cpu_en;
    prev_clean = btn_clean;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 16-clk slow tick period; the pulse, if any, appears after the third posedge.
  task automatic tick(input bit expect_pulse, input bit with_halt = 1'b0);
    slow_tick_in = 1'b1;
    clks(2);
    chk("lat_early", {31'd0, cpu_en}, 32'd0);
    if (with_halt) halt_req = 1'b1;
    clks(1);
    chk("lat_pulse", {31'd0, cpu_en}, {31'd0, expect_pulse});
    if (expect_pulse) begin
      exp_pulses++;
      exp_count++;
    end
    clks(5);
    slow_tick_in = 1'b0;
    clks(8);
    chk("step_count", {{(32-SW){1'b0}}, step_count}, 32'(exp_count % (1 << SW)));
    chk("pulse_total", pulses_seen, exp_pulses);
  endtask

  // Bouncy press: short random glitches, a long hold, then a clean release.
  task automatic press();
    int nb;
    nb = $urandom_range(1, 3);
    for (int i = 0; i < nb; i++) begin
      btn_step = 1'b1;
      clks($urandom_range(1, 2));
      btn_step = 1'b0;
      clks($urandom_range(1, 2));
    end
    btn_step = 1'b1;
    clks(10);
    chk("btn_clean_hi", {31'd0, btn_clean}, 32'd1);
    btn_step = 1'b0;
    clks(10);
    chk("btn_clean_lo", {31'd0, btn_clean}, 32'd0);
    exp_rises++;
    chk("btn_rises", rises_seen, exp_rises);
  endtask

  initial begin
    int n;
    // 1: reset, then free-run
    sw_run = 1'b1;
    clks(3);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_count", {{(32-SW){1'b0}}, step_count}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_btn", {31'd0, btn_clean}, 32'd0);
    rst = 1'b0;
    clks(4);
    chk("run_state", {30'd0, state}, 32'd1);
    for (int i = 0; i < 5; i++) tick(1'b1);
    chk("five_ticks", {{(32-SW){1'b0}}, step_count}, 32'd5);

    // 2: single step; a second press while waiting is ignored
    sw_run = 1'b0;
    clks(4);
    chk("stop_state", {30'd0, state}, 32'd0);
    press();
    chk("step_wait", {30'd0, state}, 32'd2);
    press();
    chk("step_wait2", {30'd0, state}, 32'd2);
    tick(1'b1);
    chk("step_done", {30'd0, state}, 32'd0);
    tick(1'b0);

    // 3: halt coincident with tick, then halted behaviour
    sw_run = 1'b1;
    clks(4);
    chk("run_again", {30'd0, state}, 32'd1);
    tick(1'b0, 1'b1);
    chk("halt_state", {30'd0, state}, 32'd3);
    tick(1'b0);
    press();
    chk("halt_hold", {30'd0, state}, 32'd3);
    halt_req = 1'b0;
    clks(3);
    chk("halt_sticky", {30'd0, state}, 32'd3);
    sw_run = 1'b0;
    clks(4);
    chk("halt_ack", {30'd0, state}, 32'd0);

    // 4: wrap of the step counter
    sw_run = 1'b1;
    clks(4);
    n = (1 << SW) - (exp_count % (1 << SW));
    for (int i = 0; i < n; i++) tick(1'b1);
    chk("wrap_zero", {{(32-SW){1'b0}}, step_count}, 32'd0);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) tick(1'b1);
    sw_run = 1'b0;
    clks(4);

    // 5: reset aborts a pending step
    press();
    chk("pend_state", {30'd0, state}, 32'd2);
    rst = 1'b1;
    clks(2);
    chk("abort_en", {31'd0, cpu_en}, 32'd0);
    chk("abort_state", {30'd0, state}, 32'd0);
    chk("abort_count", {{(32-SW){1'b0}}, step_count}, 32'd0);
    rst = 1'b0;
    exp_count = 0;
    clks(2);
    tick(1'b0);
    chk("abort_stop", {30'd0, state}, 32'd0);

    // 6: step_req and synced sw_run land in the same cycle; RUN wins
    btn_step = 1'b1;
    clks(4);
    sw_run = 1'b1;
    clks(3);
    chk("race_state", {30'd0, state}, 32'd1);
    exp_rises++;
    clks(6);
    btn_step = 1'b0;
    clks(6);
    chk("race_rises", rises_seen, exp_rises);
    chk("race_no_pulse", pulses_seen, exp_pulses);
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) tick(1'b1);
    chk("race_run", {30'd0, state}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
